execute_stage_pipe: RTL

//   Registered, parametrised Y86 execute stage for the pipelined core: selects ALU operands per icode, computes valE,

---
 rtl/execute_stage_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/execute_stage_pipe.sv
// execute_stage_pipe: registered Y86 execute stage (ALU, CC register, Cnd, E->M pipeline register)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   decode -> execute handshake
//   flush               squash: clears the E->M register and drops the same-cycle input
//   icode, ifun         Y86 instruction code and function
//   valA, valB, valC    operands and constant
//   dstE, dstM          destination register ids (all-ones = RNONE)
//   out_valid/out_ready execute -> memory handshake
//   out_icode, out_valE, out_valA, out_dstE, out_dstM, out_cnd, out_ins_err
//                       E->M pipeline register contents
//   cc                  {ZF,SF,OF} condition-code register
//
// Optional feature: define EXEC_MUL_EN to add mulq (OPq ifun 4), an iterative
// 1-bit/cycle shift-add multiply. Without it, ifun 4 is an illegal instruction.
module execute_stage_pipe #(
   parameter int DATA_W     = 64,
   parameter int WORD_BYTES = 8,
   parameter int REG_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [3:0]        icode,
   input  logic [3:0]        ifun,
   input  logic [DATA_W-1:0] valA,
   input  logic [DATA_W-1:0] valB,
   input  logic [DATA_W-1:0] valC,
   input  logic [REG_W-1:0]  dstE,
   input  logic [REG_W-1:0]  dstM,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_icode,
   output logic [DATA_W-1:0] out_valE,
   output logic [DATA_W-1:0] out_valA,
   output logic [REG_W-1:0]  out_dstE,
   output logic [REG_W-1:0]  out_dstM,
   output logic              out_cnd,
   output logic              out_ins_err,
   output logic [2:0]        cc
);
   localparam logic [REG_W-1:0]  RNONE = '1;
   localparam logic [DATA_W-1:0] STEP  = DATA_W'(WORD_BYTES);
`ifdef EXEC_MUL_EN
   localparam logic [3:0] OP_MAX = 4'h4;
`else
   localparam logic [3:0] OP_MAX = 4'h3;
`endif
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state, state_nx;
   logic fire, is_op, is_cnd, illegal, cond, cnd, res_of, mul_start, mul_last;
   logic zf, sf, ovf;
   logic [1:0] op;
   logic [DATA_W-1:0] alu_a, alu_b, res;
   logic [REG_W-1:0] dst_e;
   assign {zf, sf, ovf} = cc;
   assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
   assign fire     = in_valid && in_ready;
   assign is_op    = icode == 4'h6;
   assign is_cnd   = icode == 4'h2 || icode == 4'h7;
   assign illegal  = icode > 4'hB || (is_cnd && ifun > 4'h6) || (is_op && ifun > OP_MAX);
   always_comb begin
      alu_a = (icode == 4'h2 || icode == 4'h6) ? valA :
              (icode inside {4'h3, 4'h4, 4'h5}) ? valC :
              (icode == 4'h8 || icode == 4'hA) ? -STEP :
              (icode == 4'h9 || icode == 4'hB) ? STEP : '0;
      alu_b = (icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? valB : '0;
      op    = (is_op && ifun < 4'h4) ? ifun[1:0] : 2'd0;
      res   = op == 2'd1 ? alu_b - alu_a :
              op == 2'd2 ? alu_a & alu_b :
              op == 2'd3 ? alu_a ^ alu_b : alu_a + alu_b;
      // sub is valB - valA, so overflow is judged against valB's sign
      res_of = op == 2'd0 ? (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (res[DATA_W-1] != alu_a[DATA_W-1]) :
               op == 2'd1 ? (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (res[DATA_W-1] != alu_b[DATA_W-1]) : 1'b0;
      cond  = ifun == 4'h0 ? 1'b1 :
              ifun == 4'h1 ? (sf ^ ovf) | zf :
              ifun == 4'h2 ? sf ^ ovf :
              ifun == 4'h3 ? zf :
              ifun == 4'h4 ? !zf :
              ifun == 4'h5 ? !(sf ^ ovf) : !(sf ^ ovf) && !zf;
      cnd   = is_cnd && !illegal && cond;
      dst_e = (illegal || (icode == 4'h2 && !cnd)) ? RNONE : dstE;
   end
`ifdef EXEC_MUL_EN
   localparam int CNT_W = $clog2(DATA_W);
   logic [DATA_W-1:0] m_cand, m_plier, m_acc, m_vala;
   logic [REG_W-1:0]  m_dste, m_dstm;
   logic [CNT_W-1:0]  m_cnt;
   assign mul_start = fire && is_op && ifun == 4'h4;
   assign mul_last  = m_cnt == CNT_W'(DATA_W - 1);
   // shift-add: multiplicand moves left while the multiplier's LSB gates accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cand  <= '0;
         m_plier <= '0;
         m_acc   <= '0;
         m_vala  <= '0;
         m_dste  <= RNONE;
         m_dstm  <= RNONE;
         m_cnt   <= '0;
      end else if (mul_start) begin
         m_cand  <= valA;
         m_plier <= valB;
         m_acc   <= '0;
         m_vala  <= valA;
         m_dste  <= dstE;
         m_dstm  <= dstM;
         m_cnt   <= '0;
      end else if (state == MUL) begin
         m_acc   <= m_plier[0] ? m_acc + m_cand : m_acc;
         m_cand  <= m_cand << 1;
         m_plier <= m_plier >> 1;
         m_cnt   <= m_cnt + CNT_W'(1);
      end
   end
`else
   assign mul_start = 1'b0;
   assign mul_last  = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = flush ? IDLE :
                 (state == IDLE && mul_start) ? MUL :
                 (state == MUL && mul_last) ? DONE :
                 (state == DONE) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_icode   <= '0;
         out_valE    <= '0;
         out_valA    <= '0;
         out_dstE    <= RNONE;
         out_dstM    <= RNONE;
         out_cnd     <= 1'b0;
         out_ins_err <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (fire && !mul_start) begin
         out_valid   <= 1'b1;
         out_icode   <= icode;
         out_valE    <= illegal ? '0 : res;
         out_valA    <= valA;
         out_dstE    <= dst_e;
         out_dstM    <= dstM;
         out_cnd     <= cnd;
         out_ins_err <= illegal;
      end
`ifdef EXEC_MUL_EN
      else if (state == DONE) begin
         out_valid   <= 1'b1;
         out_icode   <= 4'h6;
         out_valE    <= m_acc;
         out_valA    <= m_vala;
         out_dstE    <= m_dste;
         out_dstM    <= m_dstm;
         out_cnd     <= 1'b0;
         out_ins_err <= 1'b0;
      end
`endif
      else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cc <= 3'b100;
      else if (fire && is_op && !illegal && !mul_start) cc <= {res == '0, res[DATA_W-1], res_of};
`ifdef EXEC_MUL_EN
      else if (state == DONE && !flush) cc <= {m_acc == '0, m_acc[DATA_W-1], 1'b0};
`endif
   end
endmodule
